// File: rtl/mult8x8_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult8x8_seq
// Purpose  : Sequential unsigned (2*HALF)x(2*HALF) multiplier. One HALFxHALF
//            partial-product multiplier is reused over four cycles, one nibble
//            pair per cycle. Each partial is placed by a shift and summed
//            into a 4*HALF-bit accumulator.
// Ports    : clk        - system clock, rising edge
//            reset_a    - asynchronous active-low reset
//            start      - request, sampled only in IDLE
//            dataa/b    - operands, latched when start is accepted
//            product    - result register, updated only on completion
//            done       - one-cycle completion pulse
//            busy       - high while computing (CALC)
//            input_sel  - {A nibble, B nibble} select, 0 = low, 1 = high
//            shift_sel  - partial placement: 00 none, 01 HALF, 10 2*HALF
//            state_out  - 00 IDLE, 01 CALC, 10 DONE
// Revision : 1.0 - initial release
// ============================================================================
module mult8x8_seq #(
    parameter int HALF = 4
) (
    input  logic                clk,
    input  logic                reset_a,
    input  logic                start,
    input  logic [2*HALF-1:0]   dataa,
    input  logic [2*HALF-1:0]   datab,
    output logic [4*HALF-1:0]   product,
    output logic                done,
    output logic                busy,
    output logic [1:0]          input_sel,
    output logic [1:0]          shift_sel,
    output logic [1:0]          state_out
);

    localparam int OPW = 2 * HALF;
    localparam int PW  = 4 * HALF;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_count;
    logic [OPW-1:0]     r_opa;
    logic [OPW-1:0]     r_opb;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_product;

    logic [HALF-1:0]    w_a_nib;
    logic [HALF-1:0]    w_b_nib;
    logic [OPW-1:0]     w_partial;
    logic [PW-1:0]      w_partial_ext;
    logic [PW-1:0]      w_shifted;
    logic [PW-1:0]      w_sum;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        input_sel   = 2'b00;
        shift_sel   = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy      = 1'b1;
                // The count value doubles as the {A,B} nibble select.
                input_sel = r_count;
                case (r_count)
                    2'd0:    shift_sel = 2'b00;
                    2'd3:    shift_sel = 2'b10;
                    default: shift_sel = 2'b01;   // cross terms share weight HALF
                endcase
                if (r_count == 2'd3) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Partial product datapath
    // ------------------------------------------------------------------
    assign w_a_nib = input_sel[1] ? r_opa[OPW-1:HALF] : r_opa[HALF-1:0];
    assign w_b_nib = input_sel[0] ? r_opb[OPW-1:HALF] : r_opb[HALF-1:0];

    assign w_partial     = {{HALF{1'b0}}, w_a_nib} * {{HALF{1'b0}}, w_b_nib};
    assign w_partial_ext = {{OPW{1'b0}}, w_partial};

    always_comb begin
        w_shifted = w_partial_ext;
        case (shift_sel)
            2'b01:   w_shifted = w_partial_ext << HALF;
            2'b10:   w_shifted = w_partial_ext << OPW;
            default: w_shifted = w_partial_ext;
        endcase
    end

    // The first partial restarts the sum, so no separate clear cycle is needed.
    assign w_sum = ((r_count == 2'd0) ? {PW{1'b0}} : r_acc) + w_shifted;

    // ------------------------------------------------------------------
    // Operand latch, step counter, accumulator and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_count   <= 2'd0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opa   <= dataa;
                        r_opb   <= datab;
                        r_count <= 2'd0;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_sum;
                    r_count <= r_count + 2'd1;   // wraps to 0 after step 3
                    if (r_count == 2'd3) begin
                        r_product <= w_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product   = r_product;
    assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mult8x8_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult8x8_seq
// Purpose  : Directed and random self-checking bench for mult8x8_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult8x8_seq;

    logic        clk;
    logic        reset_a;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [15:0] product;
    logic        done;
    logic        busy;
    logic [1:0]  input_sel;
    logic [1:0]  shift_sel;
    logic [1:0]  state_out;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic [1:0] exp_in [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] exp_sh [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

    mult8x8_seq #(.HALF(4)) u_dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
        .product   (product),
        .done      (done),
        .busy      (busy),
        .input_sel (input_sel),
        .shift_sel (shift_sel),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_a && done) n_done++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the accepting edge; returns with done observed high.
    task automatic wait_done(input string tag, output int busy_n);
        int cyc;
        cyc    = 0;
        busy_n = 0;
        while (done !== 1'b1 && cyc < 12) begin
            if (busy) busy_n++;
            tick();
            cyc++;
        end
        check({tag, "_done_seen"}, 16'(done), 16'd1);
    endtask

    // Full transaction from IDLE back to IDLE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        int busy_n;
        dataa = a;
        datab = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        dataa = 8'($urandom);   // post-acceptance changes must be ignored
        datab = 8'($urandom);
        wait_done(tag, busy_n);
        check({tag, "_product"}, product, exp);
        check({tag, "_busy_cycles"}, 16'(busy_n), 16'd4);
        tick();
        check({tag, "_done_width"}, 16'(done), 16'd0);
    endtask

    initial begin
        int busy_n;
        int d0;
        logic [7:0] ra, rb;

        reset_a = 1'b0;
        start   = 1'b0;
        dataa   = 8'h00;
        datab   = 8'h00;
        #1;
        check("rst_product", product, 16'h0000);
        check("rst_done",    16'(done), 16'd0);
        check("rst_busy",    16'(busy), 16'd0);
        check("rst_state",   16'(state_out), 16'd0);
        check("rst_sel",     16'({input_sel, shift_sel}), 16'd0);
        repeat (2) @(posedge clk);
        #3 reset_a = 1'b1;
        tick();

        // 1: select sequence and basic product
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_insel%0d", i), 16'(input_sel), 16'(exp_in[i]));
            check($sformatf("t1_shsel%0d", i), 16'(shift_sel), 16'(exp_sh[i]));
            check($sformatf("t1_busy%0d", i),  16'(busy), 16'd1);
            tick();
        end
        check("t1_done",    16'(done), 16'd1);
        check("t1_state",   16'(state_out), 16'd2);
        check("t1_product", product, 16'h03A8);
        tick();
        check("t1_done_low", 16'(done), 16'd0);
        check("t1_idle",     16'(state_out), 16'd0);

        // 2: maximum operands
        run_op("t2", 8'hFF, 8'hFF, 16'hFE01);

        // 3: zero operand, then start held from DONE
        dataa = 8'h00;
        datab = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t3a", busy_n);
        check("t3a_product", product, 16'h0000);
        dataa = 8'hC8;
        datab = 8'h03;
        start = 1'b1;
        tick();
        check("t3_ignored_in_done", 16'(state_out), 16'd0);
        tick();
        check("t3_accepted_in_idle", 16'(state_out), 16'd1);
        start = 1'b0;
        wait_done("t3b", busy_n);
        check("t3b_product", product, 16'h0258);
        tick();

        // 4: operand changes and a start pulse during CALC
        d0    = n_done;
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dataa = 8'hFF;
        datab = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4", busy_n);
        check("t4_product", product, 16'h03A8);
        repeat (6) tick();
        check("t4_one_done", 16'(n_done - d0), 16'd1);
        check("t4_idle",     16'(state_out), 16'd0);

        // 5: asynchronous reset mid-operation
        run_op("t5a", 8'hC8, 8'h03, 16'h0258);
        dataa = 8'hFF;
        datab = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t5_at_count2", 16'(input_sel), 16'd2);
        d0      = n_done;
        reset_a = 1'b0;
        #1;
        check("t5_rst_product", product, 16'h0000);
        check("t5_rst_outs",    16'({done, busy, input_sel, shift_sel, state_out}), 16'd0);
        repeat (2) @(posedge clk);
        #3 reset_a = 1'b1;
        tick();
        tick();
        check("t5_no_done", 16'(n_done - d0), 16'd0);
        check("t5_idle",    16'(state_out), 16'd0);
        run_op("t5b", 8'h0F, 8'h0F, 16'h00E1);

        // 6: random operands and gaps
        d0 = n_done;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op("t6", ra, rb, 16'(ra) * 16'(rb));
        end
        tick();
        check("t6_done_count", 16'(n_done - d0), 16'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
